// File: rtl/display_pkg.sv
// Shared glyph constants for the 7-segment scan display.
// All patterns are active-low, bit 0 = segment a ... bit 6 = segment g.
package display_pkg;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [3:0] AN_OFF   = 4'b1111;

endpackage

// File: rtl/seven_seg_scan_if.sv
// Digit inputs and display outputs of the scan driver.
// The producer of the digits holds master; the scan driver holds slave.
interface seven_seg_scan_if;

    logic [3:0] d0;
    logic [3:0] d1;
    logic [3:0] d2;
    logic [3:0] d3;
    logic       enable;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame_start;

    modport master (
        output d0, d1, d2, d3, enable,
        input  seg, dp, an, frame_start
    );

    modport slave (
        input  d0, d1, d2, d3, enable,
        output seg, dp, an, frame_start
    );

endinterface

// File: rtl/bcd_to_seg.sv
// BCD to active-low 7-segment glyph.
// Values above 9 render as a dash so bad data is visible.
module bcd_to_seg
    import display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // glyph lookup
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_DIGIT[0];
            4'd1:    seg = SEG_DIGIT[1];
            4'd2:    seg = SEG_DIGIT[2];
            4'd3:    seg = SEG_DIGIT[3];
            4'd4:    seg = SEG_DIGIT[4];
            4'd5:    seg = SEG_DIGIT[5];
            4'd6:    seg = SEG_DIGIT[6];
            4'd7:    seg = SEG_DIGIT[7];
            4'd8:    seg = SEG_DIGIT[8];
            4'd9:    seg = SEG_DIGIT[9];
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan.sv
// 4-digit common-anode scan driver with per-frame digit snapshot,
// anode-off guard at each digit switch and leading-zero blanking.
module seven_seg_scan
    import display_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int DP_DIGIT     = 2,
    parameter int LZ_BLANK     = 1
) (
    input  logic          clk,
    input  logic          reset,
    seven_seg_scan_if.slave bus
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] P_LAST    = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYCLES);
    localparam logic [1:0]    DP_IDX    = 2'(DP_DIGIT);

    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic [3:0]    shadow [4];
    logic          snap;
    logic          wrap;
    logic [3:0]    cur;
    logic [6:0]    glyph;
    logic [3:0]    lz_mask;
    logic          zero_hi;
    logic [3:0]    an_nxt;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;

    assign wrap = (presc == P_LAST);
    assign snap = (presc == '0) && (idx == 2'd0);
    assign cur  = shadow[idx];

    bcd_to_seg u_dec (
        .bcd (cur),
        .seg (glyph)
    );

    // slot prescaler and digit index
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc <= '0;
            idx   <= 2'd0;
        end else begin
            presc <= wrap ? '0 : presc + 1'b1;
            if (wrap)
                idx <= idx + 2'd1;
        end
    end

    // frame snapshot of the digits, with a pulse one cycle later
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow[0]       <= 4'd0;
            shadow[1]       <= 4'd0;
            shadow[2]       <= 4'd0;
            shadow[3]       <= 4'd0;
            bus.frame_start <= 1'b0;
        end else begin
            if (snap) begin
                shadow[0] <= bus.d0;
                shadow[1] <= bus.d1;
                shadow[2] <= bus.d2;
                shadow[3] <= bus.d3;
            end
            bus.frame_start <= snap;
        end
    end

    // a digit is blanked when it and every digit above it are zero
    always_comb begin
        zero_hi = 1'b1;
        lz_mask = 4'b0000;
        for (int k = 3; k >= 0; k--) begin
            zero_hi = zero_hi & (shadow[k] == 4'd0);
            if (LZ_BLANK != 0 && k > DP_DIGIT && k != 0)
                lz_mask[k] = zero_hi;
        end
    end

    // next display drive: dark in guard interval or when disabled
    always_comb begin
        an_nxt  = AN_OFF;
        seg_nxt = SEG_OFF;
        dp_nxt  = 1'b1;
        if (bus.enable && presc >= BLANK_END) begin
            an_nxt  = ~(4'b0001 << idx);
            seg_nxt = lz_mask[idx] ? SEG_OFF : glyph;
            dp_nxt  = (idx == DP_IDX) ? 1'b0 : 1'b1;
        end
    end

    // registered display outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.an  <= AN_OFF;
            bus.seg <= SEG_OFF;
            bus.dp  <= 1'b1;
        end else begin
            bus.an  <= an_nxt;
            bus.seg <= seg_nxt;
            bus.dp  <= dp_nxt;
        end
    end

endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
Consumer of the stopwatch counter's four BCD digits (d0 least significant … d3 most significant). It time-multiplexes the digits onto a 4-digit common-anode 7-segment display. It captures the digits once per scan frame so the display never tears. It also inserts an anode-off guard interval at every digit switch to suppress ghosting.

Parameters:
REFRESH_DIV, 100000, clk cycles per digit slot (1 kHz/digit at 100 MHz); legal range 2..2^20.
BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; legal range 1..REFRESH_DIV-1.
DP_DIGIT, 2, digit index (0..3) whose decimal point is lit.
LZ_BLANK, 1, 1 = leading-zero blanking enabled, 0 = disabled.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (0 = reset)
d0  input  4  BCD digit 0 (rightmost)
d1  input  4  BCD digit 1
d2  input  4  BCD digit 2
d3  input  4  BCD digit 3 (leftmost)
enable  input  1  1 = display on; 0 = all outputs dark
seg  output  7  cathodes, active-low; seg[0]=a … seg[6]=g
dp  output  1  decimal point, active-low
an  output  4  anodes, active-low; an[k] selects digit k
frame_start  output  1  one-cycle pulse, registered

Behaviour:
- Reset (reset=0, asynchronous): prescaler=0, idx=0, shadow digits=0, an=4'b1111, seg=7'h7F, dp=1, frame_start=0.
- Prescaler counts 0..REFRESH_DIV-1 and wraps. On wrap, idx advances 0→1→2→3→0. A frame is 4*REFRESH_DIV cycles.
- Snapshot: in any cycle with prescaler==0 and idx==0 (including the first cycle after reset release), the shadow registers load d0..d3. frame_start is 1 in the following cycle only.
- Input changes at any other time have no visible effect until the next snapshot.
- All of an, seg, dp are registered. The output in cycle t+1 reflects prescaler, idx and shadow in cycle t (latency 1).
- Guard interval: while prescaler < BLANK_CYCLES, an=4'b1111, seg=7'h7F, dp=1.
- Otherwise an = ~(4'b0001 << idx), seg = decode(shadow[idx]), dp = (idx==DP_DIGIT) ? 0 : 1.
- Decode of values 0..9 uses standard glyphs. Values 10..15 show a dash: only g lit, seg=7'h3F.
- Leading-zero blanking: digit k is blanked iff LZ_BLANK=1, k>DP_DIGIT, and shadow digits k..3 are all 0.
  - A blanked digit gives seg=7'h7F, and its anode is still driven.
  - Digit 0 and the DP digit are never blanked.
- enable=0 forces an=4'b1111, seg=7'h7F, dp=1 from the next cycle. Prescaler, idx, snapshot and frame_start keep running.
- Reset asserted mid-frame returns all state to reset values at once. After release, the scan restarts at idx=0 with a fresh snapshot.
- Counter widths: prescaler is $clog2(REFRESH_DIV) bits; idx is 2 bits and wraps naturally.

Decomposition:
- Package display_pkg: SEG_DIGIT[0:9] active-low glyph constants, SEG_DASH=7'h3F, SEG_OFF=7'h7F, AN_OFF=4'b1111.
- Sub-module bcd_to_seg: combinational, 4-bit BCD in, 7-bit active-low segment out, uses the package constants. Instantiated once, fed by shadow[idx].

Test Plan:
1. REFRESH_DIV=8, BLANK_CYCLES=2, d={3,2,1,0} (d3..d0). Release reset → frame_start high in cycle 2. From cycle 3, an follows 1111,1111 then 1110 for 6 cycles. The next slot shows an=1101 with seg=SEG_DIGIT[1]. The frame repeats every 32 cycles.
2. Tearing check: change d0 from 5 to 7 at prescaler==4, idx==2. Digit 0 keeps showing 5 for the rest of the frame, and shows 7 only after the next frame_start.
3. Leading-zero blanking: d={0,0,4,9}, LZ_BLANK=1, DP_DIGIT=2. Digit 3 slot gives an=0111, seg=7'h7F. Digit 2 shows SEG_DIGIT[0] with dp=0. Repeat with LZ_BLANK=0: digit 3 shows SEG_DIGIT[0].
4. Invalid BCD: d1=4'hC → during the digit 1 slot, seg=7'h3F and dp=1.
5. Enable: drop enable mid-slot → the next cycle gives an=1111, seg=7F, dp=1. frame_start pulses continue every 32 cycles. Raising enable resumes at the correct idx and prescaler phase.
6. Asynchronous reset: pull reset low between clock edges during the digit 2 slot → an=1111 and seg=7F immediately, without a clock edge. After release, frame_start appears after 1 cycle and scanning restarts at digit 0.
